// File: rtl/ram_io_responder_if.sv
// CPU byte bus, tx byte stream and halt flag of the RAM/IO responder.
// The slave modport is the responder's view; the master modport is the CPU/consumer side.
interface ram_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt_o;

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready,
        output mem_din, rdy_out, tx_data, tx_valid, halt_o
    );

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready,
        input  mem_din, rdy_out, tx_data, tx_valid, halt_o
    );
endinterface

// File: rtl/ram_io_responder.sv
// Byte RAM plus a small IO page: a tx byte FIFO with status/count registers and a sticky halt.
// Reads return one cycle later through a registered mem_din; a push into a full FIFO stalls the CPU.
module ram_io_responder #(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    ram_io_responder_if.slave     bus
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [17:0] TX_ADDR   = 18'h30000;
    localparam logic [17:0] HALT_ADDR = 18'h30004;

    logic [7:0] ram  [0:(1 << ADDR_W) - 1];
    logic [7:0] fifo [0:TX_DEPTH - 1];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_din_q, mem_din_d;
    logic             halt_q, halt_d;

    logic [17:0] addr;
    logic        io_sel;
    logic        fifo_full;
    logic        fifo_empty;
    logic        stall;
    logic        push;
    logic        pop;
    logic        ram_we;
    logic [13:0] unused_addr_bits;

    assign unused_addr_bits = bus.mem_a[31:18];
    assign addr       = bus.mem_a[17:0];
    assign io_sel     = (addr[17:16] == 2'b11);
    assign fifo_full  = (count_q == CNT_W'(TX_DEPTH));
    assign fifo_empty = (count_q == '0);

    // A pop in the same cycle does not make room: the stall depends only on the registered count.
    assign stall  = bus.mem_wr && (addr == TX_ADDR) && fifo_full;
    assign push   = bus.mem_wr && (addr == TX_ADDR) && !fifo_full && !halt_q;
    assign pop    = !fifo_empty && bus.tx_ready;
    assign ram_we = bus.mem_wr && !io_sel && !halt_q && rst_in;

    always_comb begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        count_d   = count_q;
        halt_d    = halt_q;
        mem_din_d = 8'h00;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.mem_wr && (addr == HALT_ADDR)) begin
            halt_d = 1'b1;
        end

        if (!bus.mem_wr) begin
            if (io_sel) begin
                case (addr)
                    TX_ADDR:   mem_din_d = {6'b0, fifo_full, fifo_empty};
                    HALT_ADDR: mem_din_d = 8'(count_q);
                    default:   mem_din_d = 8'h00;
                endcase
            end else begin
                mem_din_d = ram[bus.mem_a[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            halt_q    <= 1'b0;
            mem_din_q <= 8'h00;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            halt_q    <= halt_d;
            mem_din_q <= mem_din_d;
        end
    end

    // Storage arrays are not reset so RAM contents survive a reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[bus.mem_a[ADDR_W-1:0]] <= bus.mem_dout;
        end
        if (push) begin
            fifo[wr_ptr_q] <= bus.mem_dout;
        end
    end

    assign bus.mem_din  = mem_din_q;
    assign bus.rdy_out  = !stall;
    assign bus.tx_data  = fifo[rd_ptr_q];
    assign bus.tx_valid = !fifo_empty;
    assign bus.halt_o   = halt_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed scenarios plus randomized traffic, checked every cycle
// against a queue/array model of the RAM, tx FIFO and halt flag.
module tb_ram_io_responder;
    localparam int TX_DEPTH = 8;

    logic clk;
    logic rst_in;

    ram_io_responder_if bus();

    ram_io_responder #(.ADDR_W(17), .TX_DEPTH(TX_DEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ram_m  [0:131071];
    bit         ram_ok [0:131071];
    logic [7:0] m_q [$];
    logic       m_halt;
    logic [7:0] m_din;
    bit         m_din_ok;
    logic [17:0] m_a;
    bit         m_io, m_full, m_pop, m_push, m_set_halt;

    logic [7:0] popped [$];
    logic [7:0] sent   [0:8];
    logic [7:0] rd_val;
    logic [31:0] rnd_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updated on the same edge as the DUT from the inputs presented that cycle.
    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            m_q.delete();
            m_halt   = 1'b0;
            m_din    = 8'h00;
            m_din_ok = 1'b1;
        end else begin
            m_a        = bus.mem_a[17:0];
            m_io       = (m_a[17:16] == 2'b11);
            m_full     = (m_q.size() == TX_DEPTH);
            m_pop      = (m_q.size() != 0) && bus.tx_ready;
            m_push     = 1'b0;
            m_set_halt = 1'b0;
            if (bus.mem_wr) begin
                m_din    = 8'h00;
                m_din_ok = 1'b1;
                if (!m_io && !m_halt) begin
                    ram_m[bus.mem_a[16:0]]  = bus.mem_dout;
                    ram_ok[bus.mem_a[16:0]] = 1'b1;
                end
                m_push     = (m_a == 18'h30000) && !m_full && !m_halt;
                m_set_halt = (m_a == 18'h30004);
            end else if (m_io) begin
                m_din_ok = 1'b1;
                if (m_a == 18'h30000)      m_din = {6'b0, m_full, m_q.size() == 0};
                else if (m_a == 18'h30004) m_din = 8'(m_q.size());
                else                       m_din = 8'h00;
            end else begin
                m_din    = ram_m[bus.mem_a[16:0]];
                m_din_ok = ram_ok[bus.mem_a[16:0]];
            end
            if (m_pop)      void'(m_q.pop_front());
            if (m_push)     m_q.push_back(bus.mem_dout);
            if (m_set_halt) m_halt = 1'b1;
        end
    end

    // Every cycle, mid-period, the DUT outputs must match the model.
    always @(negedge clk) begin
        check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
        check("halt_o", 32'(bus.halt_o), 32'(m_halt));
        check("rdy_out", 32'(bus.rdy_out),
              32'(!(bus.mem_wr && bus.mem_a[17:0] == 18'h30000 && m_q.size() == TX_DEPTH)));
        if (m_din_ok) check("mem_din", 32'(bus.mem_din), 32'(m_din));
    end

    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) popped.push_back(bus.tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        applyStimulus(a, 1'b1, d);
        tick();
        bus.mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
        applyStimulus(a, 1'b0, 8'h00);
        tick();
        d = bus.mem_din;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in       = 1'b0;
        bus.tx_ready = 1'b0;
        applyStimulus(32'h0, 1'b0, 8'h00);
        tick();
        tick();
        check("reset tx_valid", 32'(bus.tx_valid), 32'h0);
        check("reset halt_o", 32'(bus.halt_o), 32'h0);
        check("reset mem_din", 32'(bus.mem_din), 32'h0);
        check("reset rdy_out", 32'(bus.rdy_out), 32'h1);
        rst_in = 1'b1;

        bus_write(32'h00010, 8'hA5);
        bus_read(32'h00010, rd_val);
        check("ram readback", 32'(rd_val), 32'hA5);
        bus_read(32'h30000, rd_val);
        check("status empty", 32'(rd_val), 32'h01);

        // Fill the FIFO, stall on the ninth push, then release by draining.
        for (int i = 0; i < 9; i++) sent[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) bus_write(32'h30000, sent[i]);
        bus_read(32'h30000, rd_val);
        check("status full", 32'(rd_val), 32'h02);
        bus_read(32'h30004, rd_val);
        check("count full", 32'(rd_val), 32'h08);
        applyStimulus(32'h30000, 1'b1, sent[8]);
        #1;
        check("stall on 9th", 32'(bus.rdy_out), 32'h0);
        tick();
        check("stall held", 32'(bus.rdy_out), 32'h0);
        popped.delete();
        bus.tx_ready = 1'b1;
        #1;
        check("stall during pop", 32'(bus.rdy_out), 32'h0);
        tick();
        check("ready after pop", 32'(bus.rdy_out), 32'h1);
        tick();
        applyStimulus(32'h0, 1'b0, 8'h00);
        repeat (12) tick();
        check("drained count", 32'(popped.size()), 32'd9);
        for (int i = 0; i < 9 && i < popped.size(); i++) check("drain order", 32'(popped[i]), 32'(sent[i]));
        check("drained tx_valid", 32'(bus.tx_valid), 32'h0);

        // Simultaneous push and pop leaves the count unchanged.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(32'h30000, 8'(8'h40 + i));
        bus_read(32'h30004, rd_val);
        check("count three", 32'(rd_val), 32'h03);
        applyStimulus(32'h30000, 1'b1, 8'hC3);
        bus.tx_ready = 1'b1;
        tick();
        bus.mem_wr   = 1'b0;
        bus.tx_ready = 1'b0;
        bus_read(32'h30004, rd_val);
        check("count push+pop", 32'(rd_val), 32'h03);

        // Halt blocks writes but lets the FIFO drain.
        bus_write(32'h00020, 8'h11);
        bus_write(32'h30004, 8'h00);
        check("halt set", 32'(bus.halt_o), 32'h1);
        bus_write(32'h00020, 8'h5A);
        bus_write(32'h30000, 8'h77);
        bus_read(32'h00020, rd_val);
        check("halted ram write", 32'(rd_val), 32'h11);
        bus_read(32'h30004, rd_val);
        check("halted push", 32'(rd_val), 32'h03);
        bus.tx_ready = 1'b1;
        repeat (5) tick();
        check("halted drain", 32'(bus.tx_valid), 32'h0);
        check("halt sticky", 32'(bus.halt_o), 32'h1);
        bus.tx_ready = 1'b0;

        pulse_reset();
        bus_read(32'h30008, rd_val);
        check("io other read", 32'(rd_val), 32'h00);

        // Randomized traffic; RAM addresses stay clear of 0x10/0x20 used above.
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic wr;
            if (i == 300) begin
                #1 rst_in = 1'b0;
                #1 rst_in = 1'b1;
            end
            sel = $urandom_range(0, 99);
            if (sel < 35) begin
                rnd_a = 32'($urandom_range(32'h40, 32'h7F));
                if ($urandom_range(0, 1) == 1) rnd_a[17] = 1'b1;
            end else if (sel < 65) rnd_a = 32'h30000;
            else if (sel < 80) rnd_a = 32'h30004;
            else if (sel < 90) rnd_a = 32'h30008;
            else rnd_a = 32'h30000 | 32'($urandom_range(0, 65535));
            rnd_a[31:18] = 14'($urandom);
            wr = 1'($urandom_range(0, 1));
            if (rnd_a[17:0] == 18'h30004 && wr && $urandom_range(0, 29) != 0) wr = 1'b0;
            applyStimulus(rnd_a, wr, 8'($urandom));
            bus.tx_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Asynchronous reset while stalled on a full FIFO with halt set.
        applyStimulus(32'h0, 1'b0, 8'h00);
        bus.tx_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 8; i++) bus_write(32'h30000, 8'(8'h80 + i));
        bus_write(32'h30004, 8'h00);
        applyStimulus(32'h30000, 1'b1, 8'hEE);
        #1;
        check("pre-reset stall", 32'(bus.rdy_out), 32'h0);
        check("pre-reset halt", 32'(bus.halt_o), 32'h1);
        #1 rst_in = 1'b0;
        #1;
        check("async tx_valid", 32'(bus.tx_valid), 32'h0);
        check("async halt_o", 32'(bus.halt_o), 32'h0);
        check("async rdy_out", 32'(bus.rdy_out), 32'h1);
        bus.mem_wr = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        bus_read(32'h00010, rd_val);
        check("ram survives reset", 32'(rd_val), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
